nibble_serial_sub: RTL and testbench

- Multi-cycle 16-bit subtractor for the calculator datapath; computes a - b - b_in one nibble per clock using a 4-bit subtract cell and a registered borrow chain.
- Counterpart to the 16-bit carry-select adder; serves SUB and CMP operations.
- Trades latency for area and exposes a start/ready/done handshake to the calculator control FSM.

---
 rtl/calc_pkg.sv | 15 +
 rtl/nibble_sub.sv | 27 ++
 rtl/nibble_serial_sub.sv | 162 ++++++++++++++++
 tb/tb_nibble_serial_sub.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath.
//   CALC_WIDTH / CALC_NIB_W : default operand width and nibble width.
//   state_e                 : control state encoding for multi-cycle units.
package calc_pkg;

    localparam int CALC_WIDTH = 16;
    localparam int CALC_NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_sub.sv
// Combinational nibble subtract cell: diff = a - b - bin.
// Ports:
//   a, b  : nibble operands
//   bin   : borrow in
//   diff  : nibble result
//   bout  : borrow out
// The subtraction is done as a + ~b + ~bin; a carry out of that sum means
// no borrow, so bout is the inverted carry.
module nibble_sub
    import calc_pkg::*;
#(
    parameter int NIB_W = CALC_NIB_W
) (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] diff,
    output logic             bout
);

    logic [NIB_W:0] sum;

    assign sum  = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, ~bin};
    assign diff = sum[NIB_W-1:0];
    assign bout = ~sum[NIB_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: computes a - b - b_in one nibble per clock.
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   start      : request, taken on an edge where ready is high
//   a, b, b_in : operands, captured on the accept edge
//   ready      : high in IDLE and DONE (a new request can be taken)
//   done       : one-cycle pulse, result outputs are valid
//   diff       : (a - b - b_in) mod 2^WIDTH
//   borrow     : unsigned borrow out
//   ovf        : two's-complement overflow
//   zero       : diff == 0
// Handshake: a request transfers on any rising edge where start && ready.
// Result outputs only change on the edge entering DONE (or on reset), so
// they stay stable while the next operation is running.
module nibble_serial_sub
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,   // must be a multiple of NIB_W
    parameter int NIB_W = CALC_NIB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS  = WIDTH / NIB_W;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              brw_q, brw_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [NIB_W-1:0]  a_nib, b_nib, nib_diff;
    logic              nib_bout;
    logic [WIDTH-1:0]  acc_next;
    logic              ready_int;

    assign ready_int = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Select the operand nibbles for the current step.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (step_q == i[STEP_W-1:0]) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    nibble_sub #(.NIB_W(NIB_W)) u_cell (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (brw_q),
        .diff (nib_diff),
        .bout (nib_bout)
    );

    // Accumulator with the current step's nibble replaced by the cell result.
    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < STEPS; i++) begin
            if (step_q == i[STEP_W-1:0]) begin
                acc_next[i*NIB_W +: NIB_W] = nib_diff;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        a_d      = a_q;
        b_d      = b_q;
        brw_d    = brw_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                acc_d  = acc_next;
                brw_d  = nib_bout;
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d  = ST_DONE;
                    diff_d   = acc_next;
                    borrow_d = nib_bout;
                    ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                               (acc_next[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d   = ~|acc_next;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Accepting a request from IDLE or DONE overrides the transition above.
        if (ready_int && start) begin
            state_d = ST_RUN;
            step_d  = '0;
            a_d     = a;
            b_d     = b;
            brw_d   = b_in;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            a_q      <= a_d;
            b_q      <= b_d;
            brw_q    <= brw_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign ready  = ready_int;
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub: hand-computed vectors, handshake
// sequence (ignored start in RUN, back-to-back accept from DONE) and reset
// abort in the middle of an operation.
module tb_nibble_serial_sub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        ready;
    logic        done;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] held_diff;

    nibble_serial_sub dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .b_in   (b_in),
        .ready  (ready),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .zero   (zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Issues one request while ready, walks the fixed latency and checks the
    // result in the DONE cycle, then returns to IDLE.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin, input logic [15:0] e_diff,
                          input logic e_brw, input logic e_ovf, input logic e_zero);
        logic [15:0] e;
        check_eq({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
        exp_q.push_back(e_diff);
        start = 1'b1; a = va; b = vb; b_in = vbin;
        tick();                      // E0: accept
        start = 1'b0; a = ~va; b = ~vb; b_in = ~vbin;  // later operand changes must not matter
        check_eq({tag, "_ready_run"}, {31'd0, ready}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            check_eq({tag, "_done_early"}, {31'd0, done}, 32'd0);
            check_eq({tag, "_diff_hold"}, {16'd0, diff}, {16'd0, held_diff});
            tick();                  // E1..E3
        end
        check_eq({tag, "_done_early"}, {31'd0, done}, 32'd0);
        tick();                      // E4 -> DONE
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_ready_done"}, {31'd0, ready}, 32'd1);
        e = exp_q.pop_front();
        check_eq({tag, "_diff"}, {16'd0, diff}, {16'd0, e});
        check_eq({tag, "_borrow"}, {31'd0, borrow}, {31'd0, e_brw});
        check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
        check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, e_zero});
        held_diff = e;
        tick();
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_diff_keep"}, {16'd0, diff}, {16'd0, e});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        held_diff = 16'h0000;
        tick();
        tick();
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_diff", {16'd0, diff}, 32'd0);
        check_eq("rst_flags", {29'd0, borrow, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("v3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("v4", 16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Handshake: start during RUN is ignored, start in DONE is accepted.
        start = 1'b1; a = 16'h00FF; b = 16'h000F; b_in = 1'b0;
        tick();                          // E0
        start = 1'b0;
        tick();                          // E1
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
        check_eq("hs_ready_run", {31'd0, ready}, 32'd0);
        tick();                          // E2 (ignored start)
        start = 1'b0;
        tick();                          // E3
        check_eq("hs_done_early", {31'd0, done}, 32'd0);
        tick();                          // E4
        check_eq("hs_done1", {31'd0, done}, 32'd1);
        check_eq("hs_diff1", {16'd0, diff}, 32'h00F0);
        check_eq("hs_borrow1", {31'd0, borrow}, 32'd0);
        start = 1'b1; a = 16'h0010; b = 16'h0020; b_in = 1'b0;
        tick();                          // E5: accept from DONE
        start = 1'b0;
        check_eq("hs_b2b_run", {30'd0, ready, done}, 32'd0);
        check_eq("hs_diff_hold", {16'd0, diff}, 32'h00F0);
        tick(); tick(); tick();          // E6..E8
        check_eq("hs_done_early2", {31'd0, done}, 32'd0);
        tick();                          // E9
        check_eq("hs_done2", {31'd0, done}, 32'd1);
        check_eq("hs_diff2", {16'd0, diff}, 32'hFFF0);
        check_eq("hs_borrow2", {31'd0, borrow}, 32'd1);
        check_eq("hs_ovf2", {31'd0, ovf}, 32'd0);
        tick();
        check_eq("hs_idle", {31'd0, done}, 32'd0);

        // Reset on the edge that would process step 2.
        start = 1'b1; a = 16'h1234; b = 16'h0001; b_in = 1'b0;
        tick();                          // E0
        start = 1'b0;
        tick();                          // E1
        tick();                          // E2
        rst_n = 1'b0;
        tick();                          // E3 with reset
        rst_n = 1'b1;
        check_eq("abort_ready", {31'd0, ready}, 32'd1);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_diff", {16'd0, diff}, 32'd0);
        check_eq("abort_flags", {29'd0, borrow, ovf, zero}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("abort_no_done", {31'd0, done}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
